gpio_input_conditioner: RTL and testbench
=========================================

# gpio_input_conditioner

Parametrised input-conditioning front end for the switch and button GPIO channels feeding the MicroBlaze block design. Each channel has a multi-stage synchroniser, per-channel polarity normalisation and a counter-based debouncer. Each channel produces a clean level, rise/fall pulses and a toggle latch. An optional sticky-event/IRQ stage lets firmware detect presses without polling. It replaces ad-hoc single-flop sampling of `btn`/`sw` in the top level.

## Interface
- `NUM_CH`, 16: number of independent channels (1–32).
- `SYNC_STAGES`, 2: synchroniser flops per channel (≥2).
- `DEBOUNCE_CYCLES`, 1_000_000: stable cycles required before accepting a change (10 ms at 100 MHz); ≥1. Counter width = $clog2(DEBOUNCE_CYCLES+1).
- `ACTIVE_LOW_MASK`, '0: bit i = 1 means channel i is active-low and is inverted after synchronisation.

Ports:
- `clk` in 1: single clock (100 MHz system clock).
- `reset_n` in 1: synchronous, active-low reset.
- `raw_in` in NUM_CH: asynchronous pad inputs.
- `level_o` out NUM_CH: debounced, polarity-normalised level (1 = active).
- `rise_o` out NUM_CH: one-cycle pulse on accepted 0→1 of `level_o`.
- `fall_o` out NUM_CH: one-cycle pulse on accepted 1→0 of `level_o`.
- `toggle_o` out NUM_CH: flips on every `rise_o`.
- `event_o` out NUM_CH: sticky rise flags (macro-dependent).
- `event_clr_i` in NUM_CH: per-bit clear of `event_o` (macro-dependent).
- `irq_o` out 1: OR of `event_o`, registered (macro-dependent).

## Operation
- Reset (`reset_n`=0 at a rising edge): every synchroniser flop for channel i loads ACTIVE_LOW_MASK[i], so an idle active-low input sees no edge at release. Debounce counters load 0. `level_o`, `rise_o`, `fall_o`, `toggle_o`, `event_o` and `irq_o` all load 0.
- Synchroniser: shift chain of SYNC_STAGES flops. `s` is the last stage XOR ACTIVE_LOW_MASK[i].
- Debouncer per channel:
  - If `s` == `level_o[i]`: cnt ← 0.
  - Else if cnt == DEBOUNCE_CYCLES−1: `level_o[i]` ← `s`; cnt ← 0; the matching `rise_o`/`fall_o` bit is asserted for one cycle.
  - Else: cnt ← cnt+1.
  - Any bounce back to the stable value restarts the count from 0.
- `rise_o`/`fall_o` are registered. They are high in exactly the cycle in which `level_o` first shows the new value. The two are never both high on the same channel.
- `toggle_o[i]` inverts on the same edge that sets `rise_o[i]`.
- Channels are fully independent. Simultaneous events on different channels are each reported.
- Reset mid-count discards partial counts and pending edges. No pulse is emitted at reset or at reset release.

## Timing
- Define edge 1 as the first rising edge that samples a new, stable `raw_in` value.
- `level_o`, `rise_o`/`fall_o` and `toggle_o` update at edge SYNC_STAGES + DEBOUNCE_CYCLES. With the defaults this is edge 1_000_002.
- With DEBOUNCE_CYCLES = 1, latency is SYNC_STAGES+1 edges. A change is accepted on the first cycle it differs.
- With the IRQ stage enabled, `event_o` is set on the edge after `rise_o`. `irq_o` follows `event_o` by one further edge.
- `event_clr_i` takes effect on the next edge.

## Configuration
- Macro: `GPIO_COND_IRQ_EN`.
- Defined:
  - `event_o[i]` is set on the edge after `rise_o[i]`=1.
  - It is cleared on the edge after `event_clr_i[i]`=1.
  - If set and clear occur on the same edge, set wins.
  - `irq_o` ← |`event_o` (registered).
- Not defined: the ports remain present. `event_o` and `irq_o` are tied 0, `event_clr_i` is ignored, and no event registers are synthesised.

## Test plan
- Reset release with NUM_CH=4, ACTIVE_LOW_MASK=4'b0010, raw_in=4'b0010 held for 50 cycles -> level_o=0, and rise_o/fall_o stay 0 throughout.
- DEBOUNCE_CYCLES=8, SYNC_STAGES=2: raw_in[0] 0→1 held -> level_o[0]=1 and rise_o[0]=1 for exactly one cycle at edge 10, toggle_o[0]=1. Release after 30 cycles -> fall_o[0] pulse at edge 10 after release, toggle_o[0] stays 1.
- DEBOUNCE_CYCLES=8: raw_in[1] bounces high 5 cycles, low 2 cycles, then high continuously -> exactly one rise_o[1] pulse, 10 edges after the final rising transition. There is no pulse for the 5-cycle glitch.
- Channels 0 and 3 toggle on the same cycle -> rise_o=4'b1001 in a single cycle. A second press on channel 0 -> toggle_o[0] returns to 0.
- Assert reset_n=0 for 1 cycle while channel 2 is 6 of 8 cycles into a count with the raw level held high -> all outputs 0 the cycle after reset. level_o[2] then rises 10 edges after release, not earlier.
- With `GPIO_COND_IRQ_EN` defined, channel 0 rise -> event_o[0]=1 one edge later, then irq_o=1. Assert event_clr_i[0] on the same edge as a new rise_o[0] -> event_o[0] remains 1. A clear alone -> event_o[0]=0, then irq_o=0 one edge later.

Source files
------------

// File: rtl/gpio_input_conditioner.sv
// GPIO input conditioner: per-channel synchroniser, polarity normalisation, debouncer, edge pulses and toggle latch.
// Define GPIO_COND_IRQ_EN to build the sticky rise-event flags and the registered IRQ output.
module gpio_input_conditioner #(
    parameter int                NUM_CH          = 16,
    parameter int                SYNC_STAGES     = 2,
    parameter int                DEBOUNCE_CYCLES = 1_000_000,
    parameter logic [NUM_CH-1:0] ACTIVE_LOW_MASK = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] raw_in,
    output logic [NUM_CH-1:0] level_o,
    output logic [NUM_CH-1:0] rise_o,
    output logic [NUM_CH-1:0] fall_o,
    output logic [NUM_CH-1:0] toggle_o,
    output logic [NUM_CH-1:0] event_o,
    input  logic [NUM_CH-1:0] event_clr_i,
    output logic              irq_o
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q, sync_d;
        logic [CNT_W-1:0]       cnt_q, cnt_d;
        logic                   level_q, level_d;
        logic                   rise_q, rise_d;
        logic                   fall_q, fall_d;
        logic                   toggle_q, toggle_d;
        logic                   s;

        // Normalised so that 1 always means "active", whatever the pad polarity.
        assign s = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW_MASK[gi];

        always_comb begin
            sync_d   = {sync_q[SYNC_STAGES-2:0], raw_in[gi]};
            cnt_d    = cnt_q;
            level_d  = level_q;
            rise_d   = 1'b0;
            fall_d   = 1'b0;
            toggle_d = toggle_q;
            if (s == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_d    = '0;
                level_d  = s;
                rise_d   = s;
                fall_d   = ~s;
                toggle_d = toggle_q ^ s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // Sync chain resets to the idle pad level so releasing reset never looks like an edge.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                sync_q   <= {SYNC_STAGES{ACTIVE_LOW_MASK[gi]}};
                cnt_q    <= '0;
                level_q  <= 1'b0;
                rise_q   <= 1'b0;
                fall_q   <= 1'b0;
                toggle_q <= 1'b0;
            end else begin
                sync_q   <= sync_d;
                cnt_q    <= cnt_d;
                level_q  <= level_d;
                rise_q   <= rise_d;
                fall_q   <= fall_d;
                toggle_q <= toggle_d;
            end
        end

        assign level_o[gi]  = level_q;
        assign rise_o[gi]   = rise_q;
        assign fall_o[gi]   = fall_q;
        assign toggle_o[gi] = toggle_q;
    end

`ifdef GPIO_COND_IRQ_EN
    logic [NUM_CH-1:0] event_q, event_d;
    logic              irq_q, irq_d;

    // A rise arriving on the same edge as a clear keeps the flag set.
    always_comb begin
        event_d = (event_q & ~event_clr_i) | rise_o;
        irq_d   = |event_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            event_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            event_q <= event_d;
            irq_q   <= irq_d;
        end
    end

    assign event_o = event_q;
    assign irq_o   = irq_q;
`else
    logic unused_event_clr;
    assign unused_event_clr = ^event_clr_i;
    assign event_o          = '0;
    assign irq_o            = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Directed bench for gpio_input_conditioner with a window-based behavioural model checked every cycle.
module tb_gpio_input_conditioner;
    localparam int           N    = 4;
    localparam int           SS   = 2;
    localparam int           D    = 8;
    localparam logic [N-1:0] MASK = 4'b0010;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [N-1:0] raw_in, event_clr_i;
    logic [N-1:0] level_o, rise_o, fall_o, toggle_o, event_o;
    logic         irq_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    gpio_input_conditioner #(
        .NUM_CH(N), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW_MASK(MASK)
    ) dut (
        .clk(clk), .reset_n(reset_n), .raw_in(raw_in),
        .level_o(level_o), .rise_o(rise_o), .fall_o(fall_o), .toggle_o(toggle_o),
        .event_o(event_o), .event_clr_i(event_clr_i), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    // Model: the normalised input reaches the debouncer SS edges late; a level change
    // is accepted once the last D such samples all differ from the current level.
    bit [N-1:0] m_level, m_rise, m_fall, m_toggle, m_event;
    bit         m_irq;
    bit [N-1:0] pq[$];
    bit [N-1:0] win[$];
    bit         model_valid = 1'b0;

    always @(posedge clk) begin
        bit [N-1:0] s, r, f;
        bit         ok;
        cyc++;
        if (!reset_n) begin
            pq.delete();
            for (int k = 0; k < SS; k++) pq.push_back('0);
            win.delete();
            m_level = '0; m_rise = '0; m_fall = '0; m_toggle = '0; m_event = '0; m_irq = 1'b0;
            model_valid = 1'b1;
        end else begin
`ifdef GPIO_COND_IRQ_EN
            m_irq   = |m_event;
            m_event = (m_event & ~event_clr_i) | m_rise;
`endif
            s = pq.pop_front();
            pq.push_back(raw_in ^ MASK);
            win.push_back(s);
            if (win.size() > D) void'(win.pop_front());
            r = '0;
            f = '0;
            for (int ch = 0; ch < N; ch++) begin
                ok = (win.size() == D);
                foreach (win[k]) if (win[k][ch] == m_level[ch]) ok = 1'b0;
                if (ok) begin
                    if (m_level[ch]) f[ch] = 1'b1;
                    else             r[ch] = 1'b1;
                end
            end
            m_level  = m_level ^ (r | f);
            m_toggle = m_toggle ^ r;
            m_rise   = r;
            m_fall   = f;
        end
    end

    task automatic cmp(input string nm, input logic [N-1:0] got, input logic [N-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%b exp=%b", nm, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (model_valid) begin
            cmp("level", level_o, m_level);
            cmp("rise", rise_o, m_rise);
            cmp("fall", fall_o, m_fall);
            cmp("toggle", toggle_o, m_toggle);
            cmp("event", event_o, m_event);
            cmp("irq", {{(N-1){1'b0}}, irq_o}, {{(N-1){1'b0}}, m_irq});
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [N-1:0] v);
        raw_in = v ^ MASK;
    endtask

    initial begin
        reset_n     = 1'b0;
        raw_in      = MASK;
        event_clr_i = '0;
        step(3);
        reset_n = 1'b1;
        step(50);
        cmp("idle_level", level_o, 4'b0000);
        cmp("idle_edges", rise_o | fall_o, 4'b0000);
        $display("txn idle: level=%b", level_o);

        press(4'b0001);
        step(9);
        cmp("ch0_rise_early", rise_o, 4'b0000);
        step(1);
        cmp("ch0_rise", rise_o, 4'b0001);
        cmp("ch0_level", level_o, 4'b0001);
        cmp("ch0_toggle", toggle_o, 4'b0001);
        step(1);
        cmp("ch0_rise_1cyc", rise_o, 4'b0000);
        step(19);
        press(4'b0000);
        step(10);
        cmp("ch0_fall", fall_o, 4'b0001);
        cmp("ch0_fall_toggle", toggle_o, 4'b0001);
        step(1);
        $display("txn ch0 press/release: level=%b toggle=%b", level_o, toggle_o);

        press(4'b0010); step(5);
        press(4'b0000); step(2);
        press(4'b0010);
        step(9);
        cmp("ch1_bounce_early", rise_o, 4'b0000);
        step(1);
        cmp("ch1_bounce_rise", rise_o, 4'b0010);
        press(4'b0000);
        step(12);
        $display("txn ch1 bounce: level=%b toggle=%b", level_o, toggle_o);

        press(4'b1001);
        step(10);
        cmp("ch03_rise", rise_o, 4'b1001);
        cmp("ch03_toggle", toggle_o, 4'b1010);
        press(4'b0000);
        step(12);
        $display("txn ch0+ch3: toggle=%b", toggle_o);

        press(4'b0100);
        step(8);
        reset_n = 1'b0;
        step(1);
        cmp("rst_level", level_o, 4'b0000);
        cmp("rst_toggle", toggle_o, 4'b0000);
        reset_n = 1'b1;
        step(9);
        cmp("ch2_after_rst_early", level_o, 4'b0000);
        step(1);
        cmp("ch2_after_rst_level", level_o, 4'b0100);
        cmp("ch2_after_rst_rise", rise_o, 4'b0100);
        press(4'b0000);
        step(12);
        $display("txn ch2 reset mid-count: level=%b", level_o);

`ifdef GPIO_COND_IRQ_EN
        event_clr_i = 4'b1111; step(1);
        event_clr_i = 4'b0000; step(1);
        cmp("ev_cleared", event_o, 4'b0000);
        cmp("irq_cleared", {3'b000, irq_o}, 4'b0000);
        press(4'b0001);
        step(11);
        cmp("ev_set", event_o, 4'b0001);
        step(1);
        cmp("irq_set", {3'b000, irq_o}, 4'b0001);
        press(4'b0000);
        step(12);
        press(4'b0001);
        step(10);
        event_clr_i = 4'b0001;
        step(1);
        event_clr_i = 4'b0000;
        cmp("ev_set_wins", event_o, 4'b0001);
        step(1);
        event_clr_i = 4'b0001;
        step(1);
        event_clr_i = 4'b0000;
        cmp("ev_clr", event_o, 4'b0000);
        cmp("irq_lag", {3'b000, irq_o}, 4'b0001);
        step(1);
        cmp("irq_off", {3'b000, irq_o}, 4'b0000);
        press(4'b0000);
        step(12);
`else
        event_clr_i = 4'b1111;
        step(3);
        event_clr_i = 4'b0000;
        cmp("ev_tied", event_o, 4'b0000);
        cmp("irq_tied", {3'b000, irq_o}, 4'b0000);
`endif
        $display("txn events: event=%b irq=%b", event_o, irq_o);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
